// File: rtl/multiplier_u16.sv
// 16x16 unsigned multiplier returning the low 16 product bits (a * b mod 2^16).
// Stage 1: radix-4 Booth partial products and carry-save tree; stage 2: prefix adder.
module multiplier_u16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  output logic [15:0] answer
);

  localparam int unsigned Width    = 16;
  localparam int unsigned NumPp    = 9;
  localparam int unsigned KsLevels = 4;

  typedef logic [Width-1:0] word_t;

  // Word-wide 3:2 compressor; carry vector comes back already weighted (shifted left).
  function automatic void csa3(input word_t x, input word_t y, input word_t z,
                               output word_t s, output word_t c);
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  // Word-wide 4:2 compressor built from two full-adder rows with a lateral carry.
  function automatic void comp42(input word_t w, input word_t x, input word_t y,
                                 input word_t z, output word_t s, output word_t c);
    word_t mid;
    word_t cout;
    word_t cin;
    mid  = w ^ x ^ y;
    cout = (w & x) | (w & y) | (x & y);
    cin  = cout << 1;
    s    = mid ^ z ^ cin;
    c    = ((mid & z) | (mid & cin) | (z & cin)) << 1;
  endfunction

  ///////////////////////
  // Booth recoding    //
  ///////////////////////

  logic [18:0]      b_ext;
  logic [NumPp-1:0] dig_one;
  logic [NumPp-1:0] dig_two;
  logic [NumPp-1:0] dig_neg;

  always_comb begin
    // b zero-extended to 18 bits with the implicit b[-1] = 0 appended below bit 0.
    b_ext = {2'b00, b, 1'b0};
    for (int unsigned i = 0; i < NumPp; i++) begin
      dig_one[i] = b_ext[2*i] ^ b_ext[2*i+1];
      dig_two[i] = (b_ext[2*i+2] & ~b_ext[2*i+1] & ~b_ext[2*i]) |
                   (~b_ext[2*i+2] & b_ext[2*i+1] & b_ext[2*i]);
      // Digit 111 is -0 and is treated as a plain zero.
      dig_neg[i] = b_ext[2*i+2] & ~(b_ext[2*i+1] & b_ext[2*i]);
    end
  end

  ///////////////////////
  // Partial products  //
  ///////////////////////

  word_t pp [NumPp];
  word_t pp_mag;
  word_t neg_bits;

  always_comb begin
    pp_mag   = '0;
    neg_bits = '0;
    for (int unsigned i = 0; i < NumPp; i++) begin
      pp_mag = dig_two[i] ? {a[14:0], 1'b0} : (dig_one[i] ? a : '0);
      // Negation is ~x + 1; the +1 is collected in neg_bits at the digit's weight.
      pp[i]  = (dig_neg[i] ? ~pp_mag : pp_mag) << (2*i);
    end
    // The top digit is never negative, and its weight lies beyond bit 15 anyway.
    for (int unsigned i = 0; i < NumPp - 1; i++) begin
      neg_bits[2*i] = dig_neg[i];
    end
  end

  ///////////////////////
  // Compression tree  //
  ///////////////////////

  word_t l1_s [3];
  word_t l1_c [3];
  word_t l2_s [2];
  word_t l2_c [2];
  word_t l3_s;
  word_t l3_c;
  word_t tree_sum;
  word_t tree_carry;

  always_comb begin
    // 10 operands (9 partial products + negation bits) -> 7 -> 5 -> 4 -> 2.
    csa3(pp[0], pp[1], pp[2], l1_s[0], l1_c[0]);
    csa3(pp[3], pp[4], pp[5], l1_s[1], l1_c[1]);
    csa3(pp[6], pp[7], pp[8], l1_s[2], l1_c[2]);
    csa3(l1_s[0], l1_c[0], l1_s[1], l2_s[0], l2_c[0]);
    csa3(l1_c[1], l1_s[2], l1_c[2], l2_s[1], l2_c[1]);
    csa3(l2_s[0], l2_c[0], l2_s[1], l3_s, l3_c);
    comp42(l3_s, l3_c, l2_c[1], neg_bits, tree_sum, tree_carry);
  end

  ///////////////////////
  // Stage 1 registers //
  ///////////////////////

  word_t sum_q;
  word_t carry_q;
  logic  s1_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q      <= '0;
      carry_q    <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        sum_q   <= tree_sum;
        carry_q <= tree_carry;
      end
    end
  end

  ///////////////////////
  // Kogge-Stone adder //
  ///////////////////////

  word_t ks_g [KsLevels+1];
  word_t ks_p [KsLevels];
  word_t answer_d;

  always_comb begin
    ks_g[0] = sum_q & carry_q;
    ks_p[0] = sum_q ^ carry_q;
    // Group propagates are only needed up to the second-to-last level.
    for (int unsigned l = 0; l < KsLevels - 1; l++) begin
      ks_p[l+1] = ks_p[l] & (ks_p[l] << (1 << l));
    end
    for (int unsigned l = 0; l < KsLevels; l++) begin
      ks_g[l+1] = ks_g[l] | (ks_p[l] & (ks_g[l] << (1 << l)));
    end
    // Carry into bit i is the prefix generate of bits i-1..0; carry out of bit 15 is dropped.
    answer_d = ks_p[0] ^ (ks_g[KsLevels] << 1);
  end

  ///////////////////////
  // Stage 2 registers //
  ///////////////////////

  word_t answer_q;
  logic  out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      answer_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        answer_q <= answer_d;
      end
    end
  end

  assign answer    = answer_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplier_u16.sv
// Directed and streamed checks of multiplier_u16 against hand-computed products.
module tb_multiplier_u16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [15:0] answer;

  int checks;
  int failures;

  logic [15:0] wrap_a   [4];
  logic [15:0] wrap_b   [4];
  logic [15:0] wrap_exp [4];
  logic [15:0] str_a    [4];
  logic [15:0] str_b    [4];
  logic [15:0] str_exp  [4];

  multiplier_u16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .answer    (answer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 16'h1111;
    b        = 16'h2222;
    #12;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (answer !== 16'h0000) begin
      failures++;
      $display("FAIL reset_answer: got %h expected 0000", answer);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    @(negedge clk);
    a = 16'd3; b = 16'd5; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid: got %b expected 0", out_valid);
    end
    in_valid = 1'b0; a = 16'hdead; b = 16'hbeef;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || answer !== 16'd15) begin
      failures++;
      $display("FAIL basic_result: got valid=%b answer=%h expected valid=1 answer=000f",
               out_valid, answer);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || answer !== 16'd15) begin
      failures++;
      $display("FAIL basic_hold: got valid=%b answer=%h expected valid=0 answer=000f",
               out_valid, answer);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = wrap_a[i]; b = wrap_b[i]; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || answer !== wrap_exp[i]) begin
        failures++;
        $display("FAIL wrap_%0d: got valid=%b answer=%h expected valid=1 answer=%h",
                 i, out_valid, answer, wrap_exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 2 && i < 6) begin
        checks++;
        if (out_valid !== 1'b1 || answer !== str_exp[i-2]) begin
          failures++;
          $display("FAIL stream_%0d: got valid=%b answer=%h expected valid=1 answer=%h",
                   i - 2, out_valid, answer, str_exp[i-2]);
        end
      end else if (i == 6) begin
        checks++;
        if (out_valid !== 1'b0 || answer !== 16'hfffe) begin
          failures++;
          $display("FAIL stream_end: got valid=%b answer=%h expected valid=0 answer=fffe",
                   out_valid, answer);
        end
      end
      if (i < 4) begin
        a = str_a[i]; b = str_b[i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a = 16'h0011; b = 16'h0011; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || answer !== 16'h0000) begin
      failures++;
      $display("FAIL midreset_async: got valid=%b answer=%h expected valid=0 answer=0000",
               out_valid, answer);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || answer !== 16'h0000) begin
      failures++;
      $display("FAIL midreset_lost: got valid=%b answer=%h expected valid=0 answer=0000",
               out_valid, answer);
    end
    rst_n = 1'b1;
    @(negedge clk);
    a = 16'h0102; b = 16'h0003; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_early: got valid=%b expected 0", out_valid);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || answer !== 16'h0306) begin
      failures++;
      $display("FAIL midreset_first_op: got valid=%b answer=%h expected valid=1 answer=0306",
               out_valid, answer);
    end
  endtask

  task automatic test_idle();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || answer !== 16'h0306) begin
        failures++;
        $display("FAIL idle_%0d: got valid=%b answer=%h expected valid=0 answer=0306",
                 i, out_valid, answer);
      end
      a = 16'($urandom);
      b = 16'($urandom);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_q [$];
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] prod;
    logic [15:0] expv;
    int          sent;
    int          got;
    int          cyc;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while ((sent < 100 || exp_q.size() != 0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL random_spurious: got answer=%h expected no result", answer);
        end else begin
          expv = exp_q.pop_front();
          got++;
          if (answer !== expv) begin
            failures++;
            $display("FAIL random_%0d: got %h expected %h", got - 1, answer, expv);
          end
        end
      end
      if (sent < 100 && $urandom_range(0, 2) != 0) begin
        ra   = 16'($urandom);
        rb   = 16'($urandom);
        prod = 32'(ra) * 32'(rb);
        a = ra; b = rb; in_valid = 1'b1;
        exp_q.push_back(prod[15:0]);
        sent++;
      end else begin
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 100) begin
      failures++;
      $display("FAIL random_count: got %0d results expected 100", got);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    wrap_a   = '{16'hffff, 16'h0100, 16'h8000, 16'h1234};
    wrap_b   = '{16'hffff, 16'h0100, 16'h0003, 16'h0000};
    wrap_exp = '{16'h0001, 16'h0000, 16'h8000, 16'h0000};
    str_a    = '{16'h0002, 16'h00ff, 16'habcd, 16'h7fff};
    str_b    = '{16'h0007, 16'h0101, 16'h0001, 16'h0002};
    str_exp  = '{16'h000e, 16'hffff, 16'habcd, 16'hfffe};
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
